// File: rtl/act_quant.sv
// Activation requantizer: ReLU, round-half-up shift, saturate to DATA_WIDTH.
// Two-stage valid/ready pipeline with a sticky saturation flag.
module act_quant #(
  parameter int OUTPUT_WIDTH = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int SHIFT_WIDTH  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic signed [VECTOR_WIDTH-1:0][OUTPUT_WIDTH-1:0] sum_in,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic relu_en,
  output logic out_valid,
  input  logic out_ready,
  output logic signed [VECTOR_WIDTH-1:0][DATA_WIDTH-1:0] data_out,
  input  logic clr_sat,
  output logic sat_flag
);

  localparam int AW = OUTPUT_WIDTH + 1;
  typedef logic signed [AW-1:0] acc_t;

  localparam acc_t MAXV = acc_t'(2**(DATA_WIDTH-1) - 1);
  localparam acc_t MINV = acc_t'(-(2**(DATA_WIDTH-1)));

  logic s1_valid;
  logic [VECTOR_WIDTH-1:0][AW-1:0] s1_y;
  logic [VECTOR_WIDTH-1:0][AW-1:0] y_nxt;
  logic [VECTOR_WIDTH-1:0][DATA_WIDTH-1:0] sat_d;
  logic sat_any;
  logic s1_load;
  logic s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !rst && s1_load;

  // One extra bit keeps x + 2^(shift-1) from wrapping at the top of range
  always_comb begin
    y_nxt = '0;
    for (int i = 0; i < VECTOR_WIDTH; i++) begin
      acc_t x;
      acc_t bias;
      x = {sum_in[i][OUTPUT_WIDTH-1], sum_in[i]};
      if (relu_en && sum_in[i][OUTPUT_WIDTH-1])
        x = '0;
      bias = acc_t'(1) << (shift - 1'b1);
      if (shift == '0)
        y_nxt[i] = x;
      else
        y_nxt[i] = (x + bias) >>> shift;
    end
  end

  always_comb begin
    sat_d   = '0;
    sat_any = 1'b0;
    for (int i = 0; i < VECTOR_WIDTH; i++) begin
      acc_t v;
      v = $signed(s1_y[i]);
      if (v > MAXV) begin
        v       = MAXV;
        sat_any = 1'b1;
      end else if (v < MINV) begin
        v       = MINV;
        sat_any = 1'b1;
      end
      sat_d[i] = v[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_y      <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid)
          s1_y <= y_nxt;
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid)
          data_out <= sat_d;
      end
      // A saturation on the same edge as a clear keeps the flag set
      if (s2_load && s1_valid && sat_any)
        sat_flag <= 1'b1;
      else if (clr_sat)
        sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_act_quant.sv
// Scoreboard bench for act_quant: driver pushes expected vectors,
// a negedge monitor pops and compares on every output transfer.
module tb_act_quant;

  typedef logic [3:0][15:0] vin_t;
  typedef logic [3:0][7:0]  vout_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  vin_t       sum_in;
  logic [3:0] shift;
  logic       relu_en;
  logic       out_valid;
  logic       out_ready;
  vout_t      data_out;
  logic       clr_sat;
  logic       sat_flag;

  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  vout_t q[$];

  act_quant dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum_in   (sum_in),
    .shift    (shift),
    .relu_en  (relu_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .clr_sat  (clr_sat),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vin_t vi(input int a, input int b, input int c, input int d);
    vin_t v;
    v[0] = 16'(a);
    v[1] = 16'(b);
    v[2] = 16'(c);
    v[3] = 16'(d);
    return v;
  endfunction

  function automatic vout_t vo(input int a, input int b, input int c, input int d);
    vout_t v;
    v[0] = 8'(a);
    v[1] = 8'(b);
    v[2] = 8'(c);
    v[3] = 8'(d);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got %h expected none", data_out);
      end else begin
        vout_t e;
        e = q.pop_front();
        if (data_out !== e) begin
          fails++;
          $display("FAIL data_out: got %h expected %h", data_out, e);
        end
      end
    end
  end

  task automatic send(input vin_t v, input int sh, input bit relu, input vout_t e);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    in_valid = 1'b1;
    sum_in   = v;
    shift    = 4'(sh);
    relu_en  = relu;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (ok) begin
      q.push_back(e);
    end else begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic clr_pulse();
    clr_sat = 1'b1;
    @(posedge clk);
    #1;
    clr_sat = 1'b0;
  endtask

  initial begin
    vin_t  bp_v[4];
    vout_t bp_e[4];
    vout_t snap;
    int    idx;
    int    acc;
    int    c0;
    bit    a;

    rst       = 1'b1;
    in_valid  = 1'b0;
    sum_in    = '0;
    shift     = '0;
    relu_en   = 1'b0;
    out_ready = 1'b0;
    clr_sat   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_in_ready", in_ready, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    c0 = cyc;
    send(vi(256, -256, 24, 7), 4, 0, vo(16, -16, 2, 0));
    send(vi(-3, -1, 3, 1), 1, 0, vo(-1, 0, 2, 1));
    send(vi(-8, 20, 1000, -1), 3, 1, vo(0, 3, 125, 0));
    send(vi(12, -12, 11, -13), 3, 0, vo(2, -1, 1, -2));
    send(vi(32767, -32768, 16384, -16385), 15, 0, vo(1, -1, 1, -1));
    chk("throughput_cycles", cyc - c0, 5);
    drain();
    chk("no_sat_flag", sat_flag, 0);

    send(vi(300, -300, 127, -128), 0, 0, vo(127, -128, 127, -128));
    drain();
    chk("sat_set", sat_flag, 1);
    clr_pulse();
    chk("sat_clear", sat_flag, 0);

    send(vi(300, -300, 127, -128), 0, 0, vo(127, -128, 127, -128));
    clr_pulse();
    chk("sat_set_beats_clr", sat_flag, 1);
    drain();
    clr_pulse();
    chk("sat_clear2", sat_flag, 0);

    send(vi(-5, 5, -32768, 32767), 2, 1, vo(0, 1, 0, 127));
    drain();
    chk("relu_ovf_sat", sat_flag, 1);
    clr_pulse();

    bp_v[0] = vi(1, 2, 3, 4);     bp_e[0] = vo(1, 2, 3, 4);
    bp_v[1] = vi(5, 6, 7, 8);     bp_e[1] = vo(5, 6, 7, 8);
    bp_v[2] = vi(-1, -2, -3, -4); bp_e[2] = vo(-1, -2, -3, -4);
    bp_v[3] = vi(9, 10, 11, 12);  bp_e[3] = vo(9, 10, 11, 12);
    out_ready = 1'b0;
    idx       = 0;
    acc       = 0;
    snap      = '0;
    in_valid  = 1'b1;
    sum_in    = bp_v[0];
    shift     = '0;
    relu_en   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a = in_ready;
      if (c == 3)
        snap = data_out;
      if (c == 4) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", data_out, snap);
      end
      @(posedge clk);
      #1;
      if (a) begin
        q.push_back(bp_e[idx]);
        idx++;
        acc++;
        if (idx < 4)
          sum_in = bp_v[idx];
      end
    end
    @(negedge clk);
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = idx; i < 4; i++)
      send(bp_v[i], 0, 0, bp_e[i]);
    drain();

    out_ready = 1'b0;
    send(vi(300, 0, 0, 0), 0, 0, vo(127, 0, 0, 0));
    send(vi(1, 1, 1, 1), 0, 0, vo(1, 1, 1, 1));
    chk("mid_out_valid", out_valid, 1);
    chk("mid_sat_flag", sat_flag, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_data_out", data_out, 0);
    chk("arst_sat_flag", sat_flag, 0);
    chk("arst_in_ready", in_ready, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_stale_output", out_valid, 0);
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
